ketchup_stream_feeder: RTL and testbench

Buffered, flow-controlled bridge between the Ketchup AXI register front-end and the keccak core. Register writes push tagged 32-bit words into a parametrised FIFO. The FIFO drains into the core only while core buffer_full is low. On completion, the 512-bit digest is latched into a stable output bank, a status/IRQ pulse is raised, and overflow errors are reported.

---
 rtl/ketchup_pkg.sv | 37 +++
 rtl/ketchup_word_fifo.sv | 52 +++++
 rtl/ketchup_stream_feeder.sv | 135 +++++++++++++
 tb/tb_ketchup_stream_feeder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ketchup_pkg.sv
// Shared types and constants for the Ketchup stream feeder slice.
package ketchup_pkg;

  localparam int unsigned KECCAK_WORD_W = 32;
  localparam int unsigned BYTES_W       = 2;
  localparam int unsigned ENTRY_W       = 35;

  // Bit offsets of the fields inside a flat FIFO entry.
  localparam int unsigned DATA_LSB  = 0;
  localparam int unsigned BYTES_LSB = 32;
  localparam int unsigned LAST_BIT  = 34;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ABSORB      = 2'd1,
    ST_WAIT_DIGEST = 2'd2,
    ST_DONE        = 2'd3
  } feeder_state_e;

  typedef struct packed {
    logic                     last;
    logic [BYTES_W-1:0]       bytes;
    logic [KECCAK_WORD_W-1:0] data;
  } word_entry_t;

  // Build a FIFO entry; the byte count only carries meaning on the final word.
  function automatic word_entry_t make_entry(input logic                     last,
                                             input logic [BYTES_W-1:0]       bytes,
                                             input logic [KECCAK_WORD_W-1:0] data);
    word_entry_t e;
    e.last  = last;
    e.bytes = last ? bytes : BYTES_W'(0);
    e.data  = data;
    return e;
  endfunction

endpackage

// File: rtl/ketchup_word_fifo.sv
// Show-ahead word FIFO with wrap-bit pointers, synchronous reset and flush.
module ketchup_word_fifo
  import ketchup_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned LEVEL_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign level = LEVEL_W'(wr_ptr - rd_ptr);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; flush empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/ketchup_stream_feeder.sv
// Buffered bridge from the register front-end to the keccak core with digest latch.
module ketchup_stream_feeder
  import ketchup_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned DIGEST_WIDTH = 512,
  localparam int unsigned LEVEL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [KECCAK_WORD_W-1:0] wr_data,
  input  logic                     wr_last,
  input  logic [BYTES_W-1:0]       wr_bytes,
  input  logic [1:0]               out_size,
  input  logic                     soft_reset,
  output logic                     core_reset,
  output logic [KECCAK_WORD_W-1:0] core_in,
  output logic                     core_in_ready,
  output logic                     core_is_last,
  output logic [BYTES_W-1:0]       core_byte_num,
  output logic [1:0]               core_out_size,
  input  logic                     core_buffer_full,
  input  logic [DIGEST_WIDTH-1:0]  core_out,
  input  logic                     core_out_ready,
  output logic [DIGEST_WIDTH-1:0]  digest,
  output logic                     digest_valid,
  output logic                     busy,
  output logic [LEVEL_W-1:0]       fifo_level,
  output logic                     err_overflow,
  output logic                     irq
);

  feeder_state_e            state;
  logic                     last_accepted;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ENTRY_W-1:0]       head;
  logic [ENTRY_W-1:0]       push_entry;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic                     head_last;
  logic [BYTES_W-1:0]       head_bytes;
  logic [KECCAK_WORD_W-1:0] head_data;

  // Head entry field split.
  assign head_last  = head[LAST_BIT];
  assign head_bytes = head[BYTES_LSB +: BYTES_W];
  assign head_data  = head[DATA_LSB +: KECCAK_WORD_W];

  // Front-end acceptance; reset and soft_reset both block the write path.
  assign wr_ready = !reset && !soft_reset && !fifo_full && !last_accepted &&
                    (state != ST_DONE);
  assign push     = wr_valid && wr_ready;
  assign drop     = wr_valid && !wr_ready && !soft_reset;
  assign push_entry = ENTRY_W'(make_entry(wr_last, wr_bytes, wr_data));

  // Core issue: combinational handshake, head popped on the same edge.
  assign core_in_ready = !reset && !soft_reset && (state == ST_ABSORB) &&
                         !fifo_empty && !core_buffer_full;
  assign pop           = core_in_ready;
  assign core_in       = core_in_ready ? head_data : KECCAK_WORD_W'(0);
  assign core_is_last  = core_in_ready && head_last;
  assign core_byte_num = (core_in_ready && head_last) ? head_bytes : BYTES_W'(0);

  assign busy = (state == ST_ABSORB) || (state == ST_WAIT_DIGEST);

  ketchup_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (soft_reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Feeder FSM, digest latch, sticky error and pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      last_accepted <= 1'b0;
      err_overflow  <= 1'b0;
      digest        <= '0;
      digest_valid  <= 1'b0;
      irq           <= 1'b0;
      core_out_size <= 2'd0;
      core_reset    <= 1'b1;
    end else begin
      irq        <= 1'b0;
      core_reset <= soft_reset;
      if (soft_reset) begin
        state         <= ST_IDLE;
        last_accepted <= 1'b0;
        err_overflow  <= 1'b0;
        digest        <= '0;
        digest_valid  <= 1'b0;
      end else begin
        if (drop) err_overflow <= 1'b1;
        if (push && wr_last) last_accepted <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (push) begin
              state         <= ST_ABSORB;
              core_out_size <= out_size;
            end
          end
          ST_ABSORB: begin
            if (pop && head_last) state <= ST_WAIT_DIGEST;
          end
          ST_WAIT_DIGEST: begin
            if (core_out_ready) begin
              state        <= ST_DONE;
              digest       <= core_out;
              digest_valid <= 1'b1;
              irq          <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ketchup_stream_feeder.sv
// Scoreboard bench for ketchup_stream_feeder: stimulus queues expected core words/digests,
// a negedge monitor checks them as the DUT presents them.
module tb_ketchup_stream_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid;
  logic         wr_ready;
  logic [31:0]  wr_data;
  logic         wr_last;
  logic [1:0]   wr_bytes;
  logic [1:0]   out_size;
  logic         soft_reset;
  logic         core_reset;
  logic [31:0]  core_in;
  logic         core_in_ready;
  logic         core_is_last;
  logic [1:0]   core_byte_num;
  logic [1:0]   core_out_size;
  logic         core_buffer_full;
  logic [511:0] core_out;
  logic         core_out_ready;
  logic [511:0] digest;
  logic         digest_valid;
  logic         busy;
  logic [3:0]   fifo_level;
  logic         err_overflow;
  logic         irq;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int irqs   = 0;

  logic [34:0]  exp_word_q[$];
  logic [511:0] exp_dig_q[$];

  ketchup_stream_feeder dut (
    .clk              (clk),
    .reset            (reset),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_data          (wr_data),
    .wr_last          (wr_last),
    .wr_bytes         (wr_bytes),
    .out_size         (out_size),
    .soft_reset       (soft_reset),
    .core_reset       (core_reset),
    .core_in          (core_in),
    .core_in_ready    (core_in_ready),
    .core_is_last     (core_is_last),
    .core_byte_num    (core_byte_num),
    .core_out_size    (core_out_size),
    .core_buffer_full (core_buffer_full),
    .core_out         (core_out),
    .core_out_ready   (core_out_ready),
    .digest           (digest),
    .digest_valid     (digest_valid),
    .busy             (busy),
    .fifo_level       (fifo_level),
    .err_overflow     (err_overflow),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: compare every core issue and every digest capture against the queues.
  always @(negedge clk) begin
    if (core_in_ready === 1'b1) begin
      checks++;
      pops++;
      if (exp_word_q.size() == 0) begin
        errors++;
        $display("FAIL core_word: unexpected issue got {last=%0b,bytes=%0d,data=%h}",
                 core_is_last, core_byte_num, core_in);
      end else begin
        logic [34:0] e;
        e = exp_word_q.pop_front();
        if ({core_is_last, core_byte_num, core_in} !== e) begin
          errors++;
          $display("FAIL core_word: got {last=%0b,bytes=%0d,data=%h} want {last=%0b,bytes=%0d,data=%h}",
                   core_is_last, core_byte_num, core_in, e[34], e[33:32], e[31:0]);
        end
      end
    end
    if (irq === 1'b1) begin
      checks++;
      irqs++;
      if (exp_dig_q.size() == 0) begin
        errors++;
        $display("FAIL irq: unexpected digest capture");
      end else begin
        logic [511:0] d;
        d = exp_dig_q.pop_front();
        if (digest !== d || digest_valid !== 1'b1) begin
          errors++;
          $display("FAIL digest_capture: got valid=%0b %h want %h", digest_valid, digest, d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_dig(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic [1:0] b);
    wr_valid = v;
    wr_data  = d;
    wr_last  = l;
    wr_bytes = b;
  endtask

  // Queue expected core word as the core should see it.
  task automatic expect_word(input logic [31:0] d, input logic l, input logic [1:0] b);
    exp_word_q.push_back({l, (l ? b : 2'd0), d});
  endtask

  initial begin
    reset = 1'b1; soft_reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    out_size = 2'd0; core_buffer_full = 1'b0;
    core_out = '0; core_out_ready = 1'b0;
    step(); step();

    // Reset state
    @(negedge clk);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_flags", {digest_valid, err_overflow, irq, busy, core_in_ready}, 64'd0);
    check("rst_out_size", 64'(core_out_size), 64'd0);
    check_dig("rst_digest", digest, '0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_core_reset", 64'(core_reset), 64'd1);
    step();
    @(negedge clk);
    check("core_reset_drop", 64'(core_reset), 64'd0);
    check("idle_wr_ready", 64'(wr_ready), 64'd1);

    // Three-word message, out_size changes mid-message
    step();
    out_size = 2'd2;
    drive(1'b1, 32'h61626364, 1'b0, 2'd0); expect_word(32'h61626364, 1'b0, 2'd0);
    step();
    out_size = 2'd0;
    drive(1'b1, 32'h65666768, 1'b0, 2'd0); expect_word(32'h65666768, 1'b0, 2'd0);
    step();
    drive(1'b1, 32'h696A6B6C, 1'b1, 2'd2); expect_word(32'h696A6B6C, 1'b1, 2'd2);
    step();
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    step();
    @(negedge clk);
    check("msg1_pops", 64'(pops), 64'd3);
    check("msg1_level", 64'(fifo_level), 64'd0);
    check("msg1_wait_busy", 64'(busy), 64'd1);
    check("msg1_wr_ready_after_last", 64'(wr_ready), 64'd0);
    check("msg1_out_size", 64'(core_out_size), 64'd2);

    // Digest capture
    step();
    core_out = {16{32'hA5A5A5A5}}; core_out_ready = 1'b1;
    exp_dig_q.push_back({16{32'hA5A5A5A5}});
    step();
    core_out = {16{32'h5A5A5A5A}}; core_out_ready = 1'b0;
    step();
    @(negedge clk);
    check("irq_one_pulse", {32'(irqs), 31'd0, irq}, {32'd1, 32'd0});
    check_dig("digest_hold", digest, {16{32'hA5A5A5A5}});
    check("done_flags", {digest_valid, busy}, 64'b10);
    check("done_out_size", 64'(core_out_size), 64'd2);

    // Soft reset out of DONE
    step();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    @(negedge clk);
    check("sr_core_reset", 64'(core_reset), 64'd1);
    check("sr_digest_valid", 64'(digest_valid), 64'd0);
    check_dig("sr_digest_zero", digest, '0);
    step();
    @(negedge clk);
    check("sr_core_reset_pulse", 64'(core_reset), 64'd0);

    // Overflow with core back-pressure
    step();
    core_buffer_full = 1'b1; out_size = 2'd1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10000000 + 32'(i), 1'b0, 2'd0);
      expect_word(32'h10000000 + 32'(i), 1'b0, 2'd0);
      step();
    end
    drive(1'b1, 32'hDEADBEEF, 1'b0, 2'd0);
    @(negedge clk);
    check("full_level", 64'(fifo_level), 64'd8);
    check("full_wr_ready", 64'(wr_ready), 64'd0);
    check("full_no_issue", 64'(core_in_ready), 64'd0);
    step();
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    @(negedge clk);
    check("ovf_err", 64'(err_overflow), 64'd1);
    check("ovf_level", 64'(fifo_level), 64'd8);
    step();
    core_buffer_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("drain_issue", 64'(core_in_ready), 64'd1);
      step();
    end
    @(negedge clk);
    check("drain_level", 64'(fifo_level), 64'd0);
    check("drain_out_size", 64'(core_out_size), 64'd1);
    step();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    @(negedge clk);
    check("sr_clears_err", 64'(err_overflow), 64'd0);

    // Soft reset coincident with a write in ABSORB at level 3
    step();
    core_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h20000000 + 32'(i), 1'b0, 2'd0);
      step();
    end
    drive(1'b1, 32'h2000FFFF, 1'b0, 2'd0);
    soft_reset = 1'b1;
    @(negedge clk);
    check("abs_level3", 64'(fifo_level), 64'd3);
    check("sr_blocks_write", 64'(wr_ready), 64'd0);
    step();
    soft_reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    @(negedge clk);
    check("sr_flush_level", 64'(fifo_level), 64'd0);
    check("sr_abs_core_reset", 64'(core_reset), 64'd1);
    check("sr_abs_err", 64'(err_overflow), 64'd0);
    check("sr_abs_idle", 64'(busy), 64'd0);
    step();
    core_buffer_full = 1'b0;
    @(negedge clk);
    check("sr_abs_no_issue", {core_reset, core_in_ready}, 64'd0);

    // Hard reset in WAIT_DIGEST racing core_out_ready
    step();
    out_size = 2'd3;
    drive(1'b1, 32'h71727374, 1'b1, 2'd1); expect_word(32'h71727374, 1'b1, 2'd1);
    step();
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    step();
    @(negedge clk);
    check("msg3_wait_busy", 64'(busy), 64'd1);
    check("msg3_out_size", 64'(core_out_size), 64'd3);
    step();
    reset = 1'b1; core_out_ready = 1'b1; core_out = {512{1'b1}};
    step();
    @(negedge clk);
    check("hr_flags", {irq, digest_valid, busy, err_overflow, wr_ready, core_in_ready}, 64'd0);
    check_dig("hr_digest", digest, '0);
    check("hr_out_size", 64'(core_out_size), 64'd0);
    check("hr_level", 64'(fifo_level), 64'd0);
    check("hr_core_reset", 64'(core_reset), 64'd1);
    step();
    reset = 1'b0; core_out_ready = 1'b0;
    step(); step();
    @(negedge clk);
    check("final_irq_count", 64'(irqs), 64'd1);
    check("final_queues_empty", 64'(exp_word_q.size() + exp_dig_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
